pwm_phase_driver: RTL and testbench



---
 rtl/pwm_phase_driver.sv | 90 +++++++++
 tb/tb_pwm_phase_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_phase_driver.sv
// Multi-channel phase-shifted PWM generator with a shared 8-bit period counter.
// New phase profiles are double-buffered and swapped in only at a period wrap or while disabled.
module pwm_phase_driver #(
  parameter int unsigned NUM_CHANNELS = 64,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DUTY         = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CHANNELS-1:0][7:0] phases_in,
  input  logic                         phases_valid,
  output logic [NUM_CHANNELS-1:0]      pwm_out,
  output logic                         period_start,
  output logic                         update_ack
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0]  DUTY_C    = 8'(DUTY);

  logic [15:0]                   presc_q,     presc_d;
  logic [7:0]                    phase_cnt_q, phase_cnt_d;
  logic [NUM_CHANNELS-1:0][7:0]  shadow_q,    shadow_d;
  logic [NUM_CHANNELS-1:0][7:0]  active_q,    active_d;
  logic                          pending_q,   pending_d;
  logic [NUM_CHANNELS-1:0]       pwm_q,       pwm_d;
  logic                          period_start_q, period_start_d;
  logic                          update_ack_q,   update_ack_d;

  logic tick;
  logic wrap;
  logic apply;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    presc_d        = '0;
    phase_cnt_d    = '0;
    tick           = (presc_q == PRESC_MAX);
    wrap           = en && tick && (phase_cnt_q == 8'hFF);
    // A pending profile goes live at the period wrap, or at once while idle.
    apply          = pending_q && (wrap || !en);

    if (en) begin
      presc_d     = tick ? '0 : presc_q + 16'd1;
      phase_cnt_d = tick ? phase_cnt_q + 8'd1 : phase_cnt_q;
    end

    // Apply reads the old shadow, so a coincident capture stays pending.
    shadow_d       = phases_valid ? phases_in : shadow_q;
    active_d       = apply ? shadow_q : active_q;
    pending_d      = phases_valid || (pending_q && !apply);
    period_start_d = wrap;
    update_ack_d   = apply;

    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      pwm_d[i] = en && (8'(phase_cnt_q - active_q[i]) < DUTY_C);
    end
  end

  // NOTE: the phase buffers are plain flops, not RAM, so they are cleared by
  // the async reset like every other state bit; pwm_out drops with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q        <= '0;
      phase_cnt_q    <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      update_ack_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      presc_q        <= presc_d;
      phase_cnt_q    <= phase_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      update_ack_q   <= update_ack_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign update_ack   = update_ack_q;

endmodule

// File: tb/tb_pwm_phase_driver.sv
// Randomized and directed bench for pwm_phase_driver against a clock-count based model.
module tb_pwm_phase_driver;

  localparam int NCH   = 4;
  localparam int DIV   = 1;
  localparam int DUTYV = 128;
  localparam int PER   = 256 * DIV;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en = 1'b0;
  logic                  phases_valid = 1'b0;
  logic [NCH-1:0][7:0]   phases_in = '0;
  logic [NCH-1:0]        pwm_out;
  logic                  period_start;
  logic                  update_ack;

  logic                  en5 = 1'b0;
  logic [1:0][7:0]       phases5 = '0;
  logic                  valid5 = 1'b0;
  logic [1:0]            pwm5;
  logic                  ps5;
  logic                  ack5;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  pwm_phase_driver #(.NUM_CHANNELS(NCH), .CLK_DIV(DIV), .DUTY(DUTYV)) dut (
    .clk(clk), .rst(rst), .en(en), .phases_in(phases_in), .phases_valid(phases_valid),
    .pwm_out(pwm_out), .period_start(period_start), .update_ack(update_ack)
  );

  pwm_phase_driver #(.NUM_CHANNELS(2), .CLK_DIV(3), .DUTY(1)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .phases_in(phases5), .phases_valid(valid5),
    .pwm_out(pwm5), .period_start(ps5), .update_ack(ack5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the period is the clock count since enable.
  int             m_clks = 0;
  int             m_active[NCH];
  int             m_shadow[NCH];
  bit             m_pending = 1'b0;
  logic [NCH-1:0] exp_pwm = '0;
  logic           exp_ps = 1'b0;
  logic           exp_ack = 1'b0;
  logic           m_wrap;
  logic           m_apply;

  function automatic bit pwm_level(int clks, int act);
    int phase;
    phase = (clks / DIV) % 256;
    return ((phase - act + 256) % 256) < DUTYV;
  endfunction

  assign m_wrap  = en && (m_clks == PER - 1);
  assign m_apply = m_pending && (m_wrap || !en);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clks    <= 0;
      m_pending <= 1'b0;
      exp_pwm   <= '0;
      exp_ps    <= 1'b0;
      exp_ack   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_active[i] <= 0;
        m_shadow[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        exp_pwm[i] <= en && pwm_level(m_clks, m_active[i]);
        if (m_apply) m_active[i] <= m_shadow[i];
        if (phases_valid) m_shadow[i] <= int'(phases_in[i]);
      end
      exp_ps    <= m_wrap;
      exp_ack   <= m_apply;
      m_pending <= phases_valid || (m_pending && !m_apply);
      m_clks    <= en ? (m_clks + 1) % PER : 0;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_on) begin
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("period_start", 32'(period_start), 32'(exp_ps));
      check("update_ack", 32'(update_ack), 32'(exp_ack));
    end
  end

  task automatic pulse_valid();
    phases_valid = 1'b1;
    @(negedge clk);
    phases_valid = 1'b0;
  endtask

  task automatic rand_upper();
    for (int i = 1; i < NCH; i++) phases_in[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_period_start(input string tag);
    int n;
    n = 0;
    while (!period_start && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(period_start), 32'd1);
  endtask

  initial begin
    int acks;
    int n;
    int hi[NCH];

    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_ps", 32'(period_start), 32'd0);
    check("reset_ack", 32'(update_ack), 32'd0);
    rst = 1'b1;
    chk_on = 1'b1;

    // Profile loaded while disabled applies immediately, then four phased lanes.
    phases_in = {8'd192, 8'd128, 8'd64, 8'd0};
    pulse_valid();
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(update_ack);
    end
    check("t1_ack_count", 32'(acks), 32'd1);
    en = 1'b1;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < NCH; i++) check($sformatf("t1_high_ch%0d", i), 32'(hi[i]), 32'd128);

    // Mid-period capture waits for the wrap; ack lands with period_start.
    en = 1'b0;
    phases_in = '0;
    pulse_valid();
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (50) @(negedge clk);
    phases_in[0] = 8'd100;
    rand_upper();
    pulse_valid();
    wait_period_start("t2_ps_seen");
    check("t2_ack_with_ps", 32'(update_ack), 32'd1);

    // Two captures in one period: one ack, last value wins.
    repeat (20) @(negedge clk);
    phases_in[0] = 8'd10;
    pulse_valid();
    repeat (20) @(negedge clk);
    phases_in[0] = 8'd20;
    rand_upper();
    pulse_valid();
    acks = 0;
    repeat (300) begin
      @(negedge clk);
      acks += int'(update_ack);
    end
    check("t3_ack_count", 32'(acks), 32'd1);

    // Capture exactly on the wrap while pending: old shadow applies, new one next period.
    wait_period_start("t4_align");
    repeat (5) @(negedge clk);
    phases_in[0] = 8'd20;
    pulse_valid();
    repeat (249) @(negedge clk);
    phases_in[0] = 8'd30;
    rand_upper();
    pulse_valid();
    check("t4_ack_on_wrap", 32'(update_ack), 32'd1);
    check("t4_ps_on_wrap", 32'(period_start), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!update_ack && n < 600);
    check("t4_ack_spacing", 32'(n), 32'd256);

    // Random captures and enable toggles.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) begin
        for (int i = 0; i < NCH; i++) phases_in[i] = 8'($urandom_range(0, 255));
        phases_valid = 1'b1;
      end else begin
        phases_valid = 1'b0;
      end
      if ($urandom_range(0, 999) < 3) en = ~en;
    end
    phases_valid = 1'b0;

    // Asynchronous reset mid-period with all outputs high.
    en = 1'b0;
    phases_in = '0;
    pulse_valid();
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_high_before", 32'(pwm_out), 32'hF);
    #2 rst = 1'b0;
    #1;
    check("t6_pwm_async", 32'(pwm_out), 32'd0);
    check("t6_ps_async", 32'(period_start), 32'd0);
    check("t6_ack_async", 32'(update_ack), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_restart_phase0", 32'(pwm_out), 32'hF);
    repeat (300) @(negedge clk);

    // Divided clock, minimum duty on the second instance.
    en = 1'b0;
    en5 = 1'b1;
    n = 0;
    while (!ps5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_ps_seen", 32'(ps5), 32'd1);
    n = 0;
    acks = 0;
    do begin
      @(negedge clk);
      n++;
      acks += int'(pwm5[0]);
    end while (!ps5 && n < 2000);
    check("t5_period", 32'(n), 32'd768);
    check("t5_high_clocks", 32'(acks), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
